// File: rtl/pipearch_wr_arbiter_pkg.sv
// Shared types for the CCI-P c1 write arbiter: requester IDs, counters and
// the subset of CCI-P c1 header/channel structs this block touches.
package pipearch_arb_pkg;

    localparam int N_REQ_MAX = 4;
    localparam int ID_W      = 2;

    typedef logic [ID_W-1:0] t_req_id;
    typedef logic [15:0]     t_outst_cnt;
    typedef logic [511:0]    t_ccip_clData;

    localparam logic [1:0] eCL_LEN_1    = 2'b00;
    localparam logic [3:0] eRSP_WRLINE  = 4'h1;
    localparam logic [3:0] eRSP_WRFENCE = 4'h4;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_cci_c1_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        format;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_cci_c1_RspMemHdr;

    typedef struct packed {
        t_cci_c1_ReqMemHdr hdr;
        t_ccip_clData      data;
        logic              valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_cci_c1_RspMemHdr hdr;
        logic              rspValid;
    } t_if_ccip_c1_Rx;

endpackage

// File: rtl/pipearch_wr_arbiter_if.sv
// Requester-side and CCI-P c1-side signals of the write arbiter.
// slave = arbiter view, master = requesters/shell view.
interface pipearch_wr_arbiter_if #(
    parameter int N_REQ = 2
) ();
    import pipearch_arb_pkg::*;

    logic              [N_REQ-1:0] req_valid;
    t_cci_c1_ReqMemHdr [N_REQ-1:0] req_hdr;
    t_ccip_clData      [N_REQ-1:0] req_data;
    logic              [N_REQ-1:0] req_ready;
    logic              [N_REQ-1:0] rsp_valid;
    t_outst_cnt        [N_REQ-1:0] outstanding;
    logic                          idle;
    logic                          err_id;
    logic                          c1TxAlmFull;
    t_if_ccip_c1_Rx                cp2af_sRx_c1;
    t_if_ccip_c1_Tx                af2cp_sTx_c1;

    modport slave (
        input  req_valid, req_hdr, req_data, c1TxAlmFull, cp2af_sRx_c1,
        output req_ready, rsp_valid, outstanding, idle, err_id, af2cp_sTx_c1
    );

    modport master (
        output req_valid, req_hdr, req_data, c1TxAlmFull, cp2af_sRx_c1,
        input  req_ready, rsp_valid, outstanding, idle, err_id, af2cp_sTx_c1
    );

endinterface

// File: rtl/pipearch_wr_arbiter_rr.sv
// Round-robin pick among eligible requesters; owns the rotating pointer,
// which moves just past the winner and holds when nothing is granted.
module pipearch_rr_arbiter
    import pipearch_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] i_elig,
    output logic [N_REQ-1:0] o_grant
);

    t_req_id          r_ptr;
    t_req_id          w_gnt_id;
    t_req_id          w_ptr_nxt;
    logic [N_REQ-1:0] w_hi;
    logic [N_REQ-1:0] w_grant;
    logic             w_any;

    // Lowest eligible index at/above the pointer wins; otherwise wrap to the
    // lowest eligible index overall.
    always_comb begin
        w_hi     = '0;
        w_grant  = '0;
        w_gnt_id = '0;
        w_any    = 1'b0;
        for (int j = 0; j < N_REQ; j++)
            w_hi[j] = i_elig[j] && (t_req_id'(j) >= r_ptr);
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && w_hi[j]) begin
                w_any      = 1'b1;
                w_grant[j] = 1'b1;
                w_gnt_id   = t_req_id'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && i_elig[j]) begin
                w_any      = 1'b1;
                w_grant[j] = 1'b1;
                w_gnt_id   = t_req_id'(j);
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_id == t_req_id'(N_REQ - 1)) ? '0 : w_gnt_id + t_req_id'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_ptr <= '0;
        else if (w_any) r_ptr <= w_ptr_nxt;
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/pipearch_wr_arbiter.sv
// Shares CCI-P c1 among N_REQ write requesters: round-robin grant, one-cycle
// registered Tx stage, per-requester outstanding caps and ack routing via mdata.
module pipearch_wr_arbiter
    import pipearch_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipearch_wr_arbiter_if.slave arb_if
);

    t_outst_cnt [N_REQ-1:0] r_cnt;
    logic       [N_REQ-1:0] w_elig;
    logic       [N_REQ-1:0] w_grant;
    logic       [N_REQ-1:0] w_ack_ok;
    logic       [N_REQ-1:0] w_nz;
    logic       [N_REQ-1:0] r_rsp;
    logic                   r_err;
    logic                   r_tx_valid;
    logic                   w_ack_vld;
    logic                   w_err_set;
    logic                   w_unused_rx;
    t_req_id                w_ack_id;
    t_cci_c1_ReqMemHdr      w_tx_hdr;
    t_cci_c1_ReqMemHdr      r_tx_hdr;
    t_ccip_clData           w_tx_data;
    t_ccip_clData           r_tx_data;

    // reset_n gates eligibility so nothing is granted while reset is held.
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_req
            assign w_elig[i]   = reset_n && arb_if.req_valid[i] && !arb_if.c1TxAlmFull &&
                                 (r_cnt[i] < t_outst_cnt'(MAX_OUTST));
            assign w_ack_ok[i] = w_ack_vld && (w_ack_id == t_req_id'(i)) && (r_cnt[i] != '0);
            assign w_nz[i]     = |r_cnt[i];
        end
    endgenerate

    pipearch_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    always_comb begin
        w_tx_hdr  = '0;
        w_tx_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_tx_hdr                 = arb_if.req_hdr[i];
                w_tx_hdr.mdata[ID_W-1:0] = t_req_id'(i);
                w_tx_data                = arb_if.req_data[i];
            end
        end
    end

    // Any WRLINE ack that does not land on a live counter is an ID error.
    assign w_ack_vld   = arb_if.cp2af_sRx_c1.rspValid &&
                         (arb_if.cp2af_sRx_c1.hdr.resp_type == eRSP_WRLINE);
    assign w_ack_id    = arb_if.cp2af_sRx_c1.hdr.mdata[ID_W-1:0];
    assign w_err_set   = w_ack_vld && !(|w_ack_ok);
    assign w_unused_rx = ^{arb_if.cp2af_sRx_c1.hdr.vc_used, arb_if.cp2af_sRx_c1.hdr.format,
                           arb_if.cp2af_sRx_c1.hdr.cl_num, arb_if.cp2af_sRx_c1.hdr.mdata[15:ID_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_rsp      <= '0;
            r_err      <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_rsp      <= w_ack_ok;
            r_err      <= r_err | w_err_set;
            r_tx_valid <= |w_grant;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant[i] && !w_ack_ok[i])
                    r_cnt[i] <= r_cnt[i] + t_outst_cnt'(1);
                else if (!w_grant[i] && w_ack_ok[i])
                    r_cnt[i] <= r_cnt[i] - t_outst_cnt'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (|w_grant) begin
            r_tx_hdr  <= w_tx_hdr;
            r_tx_data <= w_tx_data;
        end
    end

    assign arb_if.req_ready    = w_grant;
    assign arb_if.rsp_valid    = r_rsp;
    assign arb_if.outstanding  = r_cnt;
    assign arb_if.err_id       = r_err;
    assign arb_if.idle         = !(|w_nz) && !r_tx_valid;
    assign arb_if.af2cp_sTx_c1 = '{hdr: r_tx_hdr, data: r_tx_data, valid: r_tx_valid};

endmodule

// File: doc/pipearch_wr_arbiter.md
PIPEARCH_WR_ARBITER -- requirements
Module: pipearch_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of write requesters sharing CCI-P c1; legal range 2..4.
REQ-002 Parameter MAX_OUTST, default 64, per-requester cap on outstanding (issued, unacknowledged) writes; legal range 1..65535.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  N_REQ  requester i has a write line ready.
REQ-006 req_hdr  in  N_REQ x t_cci_c1_ReqMemHdr  write header per requester.
REQ-007 req_data  in  N_REQ x t_ccip_clData  512-bit line per requester.
REQ-008 req_ready  out  N_REQ  one-hot grant, combinational; transfer when req_valid[i] & req_ready[i].
REQ-009 rsp_valid  out  N_REQ  one-cycle pulse per write acknowledge routed to requester i.
REQ-010 outstanding  out  N_REQ x 16  current outstanding count per requester.
REQ-011 idle  out  1  high when no write is outstanding and no request is staged.
REQ-012 err_id  out  1  sticky; set by an acknowledge carrying an out-of-range requester ID.
REQ-013 c1TxAlmFull  in  1  CCI-P c1 Tx almost-full.
REQ-014 cp2af_sRx_c1  in  t_if_ccip_c1_Rx  c1 response channel.
REQ-015 af2cp_sTx_c1  out  t_if_ccip_c1_Tx  c1 request channel, registered.

Function
REQ-016 Eligible(i) = req_valid[i] & !c1TxAlmFull & outstanding[i] < MAX_OUTST.
REQ-017 Round-robin: search starts at rr_ptr and wraps modulo N_REQ; the first eligible requester gets req_ready; at most one bit high.
REQ-018 On grant of i, rr_ptr <= (i+1) mod N_REQ; with no grant, rr_ptr holds.
REQ-019 c1TxAlmFull high forces req_ready to all-zero in the same cycle.
REQ-020 Accepted request appears on af2cp_sTx_c1 the next cycle with valid=1 for exactly one cycle. Latency is 1 cycle.
REQ-021 Forwarded hdr = req_hdr verbatim except mdata[ID_W-1:0] <= i; data forwarded verbatim.
REQ-022 Requesters SHALL issue single-line writes only (cl_len = eCL_LEN_1, sop = 1). The arbiter does not check this.
REQ-023 af2cp_sTx_c1.valid is 0 in every cycle without an accepted request.
REQ-024 Acknowledge: cp2af_sRx_c1.rspValid with resp_type eRSP_WRLINE and mdata[ID_W-1:0] = k < N_REQ pulses rsp_valid[k] the next cycle.
REQ-025 Acknowledges with any other resp_type are ignored.
REQ-026 Acknowledge with k >= N_REQ is dropped, sets err_id, and changes no counter.
REQ-027 outstanding[i] +1 on issue and -1 on acknowledge; simultaneous issue and acknowledge for the same i leaves it unchanged.
REQ-028 outstanding[i] never exceeds MAX_OUTST and never decrements below 0; an acknowledge at 0 is dropped and sets err_id.
REQ-029 idle = (all outstanding == 0) & !af2cp_sTx_c1.valid.

Reset
REQ-030 reset_n low asynchronously clears: af2cp_sTx_c1.valid, rsp_valid, outstanding, rr_ptr (to 0), err_id. idle reads 1; req_ready is 0 while reset_n is low.
REQ-031 Reset asserted mid-traffic discards staged and outstanding state; acknowledges arriving after release with a counter at 0 follow REQ-028.
REQ-032 The af2cp_sTx_c1 hdr/data payload is not reset; only valid is.

Structure
REQ-033 The package pipearch_arb_pkg holds N_REQ_MAX=4, ID_W=2, typedef t_req_id, and typedef t_outst_cnt (16 bits).
REQ-034 Round-robin selection lives in sub-module pipearch_rr_arbiter (eligible vector, rr_ptr in; one-hot grant out; owns rr_ptr register).
REQ-035 Counters and response routing stay in pipearch_wr_arbiter.

Verification
REQ-036 Both requesters valid continuously, c1TxAlmFull=0, 8 cycles -> grants alternate 0,1,0,1...; 8 writes issued, with mdata[1:0] alternating 0,1.
REQ-037 c1TxAlmFull=1 for 5 cycles with both requesters valid -> req_ready=0 and no Tx valid; on deassert, requester at rr_ptr is granted first.
REQ-038 MAX_OUTST=2, requester 0 issues 2 lines with no acks -> req_ready[0] stays 0 while requester 1 keeps being granted; one ack (mdata=0) -> requester 0 is granted again.
REQ-039 Same-cycle issue and ack for requester 1 at outstanding=3 -> outstanding[1] stays 3, rsp_valid[1] pulses once.
REQ-040 Ack with mdata[1:0]=3 at N_REQ=2 -> err_id=1 and stays set, counters unchanged; ack at outstanding=0 -> err_id=1.
REQ-041 reset_n pulsed low with 5 writes outstanding -> all outputs are reset values immediately, idle=1, next grant goes to requester 0.
